muldiv_seq: RTL and testbench
=============================

Name: muldiv_seq

Overview:
- Execute-stage sequencer for a shared iterative multiply/divide unit, driven by the decoded multiply/divide ops (MUL, UMULL, SMULL, UDIV).
- Captures operands when the op enters E and runs a radix-2 shift-add multiply or restoring divide, one bit per cycle.
- Holds F/D/E stalled via StallMD until the result is ready, then presents a one-cycle result strobe to the E/M pipeline register.
- Honours flushes (Abort) at any point.

Parameters:
- WIDTH, 32, operand width; product is 2*WIDTH; iteration counter is clog2(WIDTH) bits.

Ports:
- clk  input  1  core clock, rising edge
- reset  input  1  synchronous, active-high
- StartE  input  1  multiply/divide op present in E; sampled only in IDLE
- OpE  input  2  00 MUL, 01 UMULL, 10 SMULL, 11 UDIV
- SrcAE  input  WIDTH  multiplicand / dividend
- SrcBE  input  WIDTH  multiplier / divisor
- Abort  input  1  flush of E (e.g. FlushE); kills the in-flight op
- StallMD  output  1  hold F, D, E (combinational)
- ResultValid  output  1  one-cycle result strobe
- ResultLo  output  WIDTH  product[WIDTH-1:0] or quotient
- ResultHi  output  WIDTH  product[2*WIDTH-1:WIDTH] or remainder
- DivByZero  output  1  qualifies ResultValid; UDIV with SrcBE==0

Behaviour:
- Reset: state=IDLE; ResultLo=0, ResultHi=0, DivByZero=0, counter=0; ResultValid=0 and StallMD=0 in the first cycle after reset. Reset mid-operation discards the operation with no strobe.
- States: IDLE, BUSY, DONE.
- StallMD = (IDLE & StartE & ~Abort) | BUSY. It is low in DONE, so the held instruction advances exactly with the strobe.
- ResultValid = DONE & ~Abort. Results are registered and hold their last value between strobes.

IDLE:
- StartE & ~Abort (cycle T): latch operands; counter=0; next state BUSY.
- Exception: UDIV with SrcBE==0 goes straight to DONE with ResultLo=all-ones, ResultHi=SrcAE, DivByZero=1.
- Otherwise DivByZero is cleared on start.

BUSY:
- One iteration per cycle; counter increments.
- After the iteration with counter==WIDTH-1, next state is DONE.
- Exactly WIDTH BUSY cycles: T+1..T+WIDTH. DONE/strobe at T+WIDTH+1. StallMD high for WIDTH+1 cycles.

DONE:
- One cycle, then IDLE.
- StartE in this cycle is ignored; the next op is seen in IDLE the following cycle.

Abort:
- Priority over everything.
- In IDLE it blocks the start. In BUSY or DONE the next state is IDLE, with no strobe and output registers unchanged.

Ops and arithmetic:
- SMULL: operands converted to magnitudes at start; the 2*WIDTH result is negated at completion if the sign bits differ. Most-negative operands are handled as unsigned magnitude 2^(WIDTH-1).
- MUL: same datapath and both halves as UMULL (ResultHi defined, unused by writeback).
- UDIV: restoring shift-subtract. Quotient goes to ResultLo, remainder to ResultHi.
- StartE during BUSY or DONE is ignored; no queueing.

Optional Feature:
- Macro: MULDIV_EARLY_EXIT_EN.
- Defined: in BUSY for MUL/UMULL/SMULL, if the right-shifted multiplier magnitude becomes zero after an iteration, the next state is DONE. Latency becomes (index of highest set multiplier bit + 1) BUSY cycles, minimum 1.
- UDIV is unaffected.
- Not defined: always WIDTH BUSY cycles.

Test Plan:
- UMULL 0xFFFFFFFF x 0xFFFFFFFF, start at T: StallMD high T..T+32; ResultValid only at T+33 with Hi=0xFFFFFFFE, Lo=0x00000001.
- SMULL 0xFFFFFFFD (-3) x 7: Hi=0xFFFFFFFF, Lo=0xFFFFFFEB. SMULL 0x80000000 x 0x80000000: Hi=0x40000000, Lo=0.
- UDIV 100/7: Lo=14, Hi=2, DivByZero=0. UDIV 0x1234/0: strobe at T+1, Lo=0xFFFFFFFF, Hi=0x1234, DivByZero=1, StallMD high only at T.
- Abort at T+10 during UMULL: IDLE at T+11 with StallMD=0 and no strobe; a new MUL 6x7 started at T+12 gives Lo=42 at T+45.
- Mid-operation events:
  - Reset asserted at T+5: all outputs 0 from the next cycle.
  - Abort coincident with DONE: ResultValid stays 0.
  - StartE held high through DONE: exactly one op executes.
- With MULDIV_EARLY_EXIT_EN: MUL 5x3 strobes at T+3 with Lo=15; MUL 9x0 strobes at T+2 with Lo=0.
- Without MULDIV_EARLY_EXIT_EN: MUL 5x3 strobes at T+33.

Source files
------------

// File: rtl/muldiv_seq.sv
// Iterative radix-2 multiply / restoring divide sequencer for the E stage.
// Define MULDIV_EARLY_EXIT_EN to finish multiplies once the multiplier runs out.
module muldiv_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             StartE,
  input  logic [1:0]       OpE,
  input  logic [WIDTH-1:0] SrcAE,
  input  logic [WIDTH-1:0] SrcBE,
  input  logic             Abort,
  output logic             StallMD,
  output logic             ResultValid,
  output logic [WIDTH-1:0] ResultLo,
  output logic [WIDTH-1:0] ResultHi,
  output logic             DivByZero
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [1:0] OP_SMULL = 2'b10;
  localparam logic [1:0] OP_UDIV  = 2'b11;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t             state, stateNext;
  logic [2*WIDTH-1:0] acc, accNext, mcand, prodFinal;
  logic [WIDTH-1:0]   mplier, magA, magB;
  logic [WIDTH-1:0]   heldLo, heldHi;
  logic [WIDTH:0]     remShift, diff;
  logic [CW-1:0]      cnt;
  logic [1:0]         op;
  logic               negRes, dbz, heldDbz;
  logic               startSigned, startDiv, divZero;
  logic               lastIter, go;

  always_comb begin
    startSigned = (OpE == OP_SMULL);
    startDiv    = (OpE == OP_UDIV);
    divZero     = startDiv && (SrcBE == '0);
    magA = (startSigned && SrcAE[WIDTH-1]) ? -SrcAE : SrcAE;
    magB = (startSigned && SrcBE[WIDTH-1]) ? -SrcBE : SrcBE;
    go   = StartE && !Abort;
  end

  // Divide keeps {remainder, quotient} in acc; multiply accumulates the product.
  always_comb begin
    remShift = acc[2*WIDTH-1:WIDTH-1];
    diff     = remShift - {1'b0, mcand[WIDTH-1:0]};
    if (op == OP_UDIV) begin
      if (diff[WIDTH])
        accNext = {remShift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
      else
        accNext = {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    end else begin
      accNext = acc + (mplier[0] ? mcand : '0);
    end
    prodFinal = negRes ? -acc : acc;
  end

  always_comb begin
`ifdef MULDIV_EARLY_EXIT_EN
    lastIter = (cnt == CW'(WIDTH-1)) ||
               ((op != OP_UDIV) && ((mplier >> 1) == '0));
`else
    lastIter = (cnt == CW'(WIDTH-1));
`endif
  end

  always_comb begin
    stateNext   = state;
    StallMD     = 1'b0;
    ResultValid = 1'b0;
    unique case (state)
      IDLE: begin
        if (go) begin
          StallMD   = 1'b1;
          stateNext = divZero ? DONE : BUSY;
        end
      end
      BUSY: begin
        StallMD = 1'b1;
        if (Abort)
          stateNext = IDLE;
        else if (lastIter)
          stateNext = DONE;
      end
      DONE: begin
        stateNext   = IDLE;
        ResultValid = !Abort;
      end
      default: stateNext = IDLE;
    endcase
  end

  // Result bus shows the fresh value only on the strobe, else the last one.
  always_comb begin
    ResultLo  = ResultValid ? prodFinal[WIDTH-1:0]       : heldLo;
    ResultHi  = ResultValid ? prodFinal[2*WIDTH-1:WIDTH] : heldHi;
    DivByZero = ResultValid ? dbz                        : heldDbz;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      acc     <= '0;
      mcand   <= '0;
      mplier  <= '0;
      op      <= '0;
      negRes  <= 1'b0;
      dbz     <= 1'b0;
      heldLo  <= '0;
      heldHi  <= '0;
      heldDbz <= 1'b0;
    end else begin
      state <= stateNext;
      unique case (state)
        IDLE: begin
          if (go) begin
            op     <= OpE;
            cnt    <= '0;
            dbz    <= divZero;
            negRes <= startSigned && (SrcAE[WIDTH-1] ^ SrcBE[WIDTH-1]);
            mplier <= magB;
            if (divZero) begin
              acc   <= {SrcAE, {WIDTH{1'b1}}};
              mcand <= '0;
            end else if (startDiv) begin
              acc   <= {{WIDTH{1'b0}}, SrcAE};
              mcand <= {{WIDTH{1'b0}}, SrcBE};
            end else begin
              acc   <= '0;
              mcand <= {{WIDTH{1'b0}}, magA};
            end
          end
        end
        BUSY: begin
          acc    <= accNext;
          mplier <= mplier >> 1;
          cnt    <= cnt + 1'b1;
          if (op != OP_UDIV)
            mcand <= mcand << 1;
        end
        DONE: begin
          if (!Abort) begin
            heldLo  <= prodFinal[WIDTH-1:0];
            heldHi  <= prodFinal[2*WIDTH-1:WIDTH];
            heldDbz <= dbz;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed bench for muldiv_seq with a result scoreboard.
// Latencies follow MULDIV_EARLY_EXIT_EN when it is defined.
module tb_muldiv_seq;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset, StartE, Abort;
  logic [1:0]   OpE;
  logic [W-1:0] SrcAE, SrcBE;
  logic         StallMD, ResultValid, DivByZero;
  logic [W-1:0] ResultLo, ResultHi;

  muldiv_seq #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .StartE(StartE), .OpE(OpE),
    .SrcAE(SrcAE), .SrcBE(SrcBE), .Abort(Abort),
    .StallMD(StallMD), .ResultValid(ResultValid),
    .ResultLo(ResultLo), .ResultHi(ResultHi),
    .DivByZero(DivByZero)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    logic [W-1:0] lo;
    logic [W-1:0] hi;
    logic         d;
    int           at;
  } exp_t;

  exp_t         sbq[$];
  exp_t         mon;
  int           checks = 0;
  int           fails = 0;
  logic [W-1:0] lastLo = '0;
  logic [W-1:0] lastHi = '0;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int mulLat(input logic [W-1:0] b);
`ifdef MULDIV_EARLY_EXIT_EN
    int n = 1;
    for (int i = 0; i < W; i++)
      if (b[i]) n = i + 1;
    return n + 1;
`else
    return W + 1;
`endif
  endfunction

  always @(negedge clk) begin
    if (ResultValid === 1'b1) begin
      if (sbq.size() == 0) begin
        chk("spurious strobe", 64'(ResultValid), 64'd0);
      end else begin
        mon = sbq.pop_front();
        chk("ResultLo", 64'(ResultLo), 64'(mon.lo));
        chk("ResultHi", 64'(ResultHi), 64'(mon.hi));
        chk("DivByZero", 64'(DivByZero), 64'(mon.d));
        chk("strobe cycle", 64'(cyc), 64'(mon.at));
      end
    end
  end

  task automatic runOp(input logic [1:0] op, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [W-1:0] lo,
                       input logic [W-1:0] hi, input logic d,
                       input int lat, input bit hold);
    int t;
    @(posedge clk); #1;
    StartE = 1'b1; OpE = op; SrcAE = a; SrcBE = b;
    t = cyc;
    sbq.push_back('{lo, hi, d, t + lat});
    for (int i = 0; i <= lat; i++) begin
      @(negedge clk);
      chk("StallMD", 64'(StallMD), 64'(i < lat));
      @(posedge clk); #1;
      if (!hold) StartE = 1'b0;
    end
    StartE = 1'b0;
    chk("scoreboard drained", 64'(sbq.size()), 64'd0);
    lastLo = lo;
    lastHi = hi;
  endtask

  initial begin
    reset = 1'b1; StartE = 1'b0; Abort = 1'b0;
    OpE = 2'b00; SrcAE = '0; SrcBE = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("reset ResultLo", 64'(ResultLo), 64'd0);
    chk("reset ResultHi", 64'(ResultHi), 64'd0);
    chk("reset DivByZero", 64'(DivByZero), 64'd0);
    chk("reset ResultValid", 64'(ResultValid), 64'd0);
    chk("reset StallMD", 64'(StallMD), 64'd0);

    runOp(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001,
          32'hFFFF_FFFE, 1'b0, mulLat(32'hFFFF_FFFF), 1'b0);
    runOp(2'b10, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFEB,
          32'hFFFF_FFFF, 1'b0, mulLat(32'd7), 1'b0);
    runOp(2'b10, 32'h8000_0000, 32'h8000_0000, 32'h0,
          32'h4000_0000, 1'b0, mulLat(32'h8000_0000), 1'b0);
    runOp(2'b11, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, W + 1, 1'b0);
    runOp(2'b11, 32'h1234, 32'd0, 32'hFFFF_FFFF, 32'h1234,
          1'b1, 1, 1'b0);
    runOp(2'b00, 32'd5, 32'd3, 32'd15, 32'd0, 1'b0, mulLat(32'd3), 1'b0);
    runOp(2'b00, 32'd9, 32'd0, 32'd0, 32'd0, 1'b0, mulLat(32'd0), 1'b0);

    // Abort mid-multiply, then restart two cycles later
    @(posedge clk); #1;
    StartE = 1'b1; OpE = 2'b01; SrcAE = 32'h1234_5678; SrcBE = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    StartE = 1'b0;
    repeat (9) @(posedge clk);
    #1 Abort = 1'b1;
    @(negedge clk);
    chk("abort BUSY StallMD", 64'(StallMD), 64'd1);
    @(posedge clk); #1;
    Abort = 1'b0;
    @(negedge clk);
    chk("post-abort StallMD", 64'(StallMD), 64'd0);
    chk("post-abort ResultValid", 64'(ResultValid), 64'd0);
    chk("post-abort ResultLo", 64'(ResultLo), 64'(lastLo));
    chk("post-abort ResultHi", 64'(ResultHi), 64'(lastHi));
    runOp(2'b00, 32'd6, 32'd7, 32'd42, 32'd0, 1'b0, mulLat(32'd7), 1'b0);

    // Abort coincident with DONE suppresses the strobe
    @(posedge clk); #1;
    StartE = 1'b1; OpE = 2'b11; SrcAE = 32'd50; SrcBE = 32'd5;
    @(posedge clk); #1;
    StartE = 1'b0;
    repeat (W) @(posedge clk);
    #1 Abort = 1'b1;
    @(negedge clk);
    chk("abort DONE ResultValid", 64'(ResultValid), 64'd0);
    chk("abort DONE StallMD", 64'(StallMD), 64'd0);
    @(posedge clk); #1;
    Abort = 1'b0;
    @(negedge clk);
    chk("abort DONE ResultLo", 64'(ResultLo), 64'(lastLo));
    chk("abort DONE ResultHi", 64'(ResultHi), 64'(lastHi));
    chk("abort DONE DivByZero", 64'(DivByZero), 64'd0);

    // StartE held high through DONE runs exactly one op
    runOp(2'b00, 32'd2, 32'd3, 32'd6, 32'd0, 1'b0, mulLat(32'd3), 1'b1);
    repeat (40) begin
      @(negedge clk);
      chk("held StartE idle StallMD", 64'(StallMD), 64'd0);
    end

    // Reset in the middle of an operation
    @(posedge clk); #1;
    StartE = 1'b1; OpE = 2'b01; SrcAE = 32'hFFFF_FFFF; SrcBE = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    StartE = 1'b0;
    repeat (4) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("mid reset ResultLo", 64'(ResultLo), 64'd0);
    chk("mid reset ResultHi", 64'(ResultHi), 64'd0);
    chk("mid reset DivByZero", 64'(DivByZero), 64'd0);
    chk("mid reset ResultValid", 64'(ResultValid), 64'd0);
    chk("mid reset StallMD", 64'(StallMD), 64'd0);
    runOp(2'b01, 32'd3, 32'd4, 32'd12, 32'd0, 1'b0, mulLat(32'd4), 1'b0);

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

endmodule
